// File: rtl/nbit_seq_alu.sv
// Registered ALU with accumulator; non-MUL results 1 cycle after accept, MUL after N cycles.
// Backpressure: in_ready drops while a result is unconsumed or a MUL is running.
module nbit_seq_alu #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic         use_acc,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic [N-1:0] result_hi,
    output logic         carry,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);
    localparam int CW = $clog2(N);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_NOT = 4'd5, OP_INC = 4'd6, OP_DEC = 4'd7,
                           OP_SHL = 4'd8, OP_SHR = 4'd9, OP_MUL = 4'd10;
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          r_state, w_state_nxt;
    logic [N-1:0]    r_acc, r_mul_a, r_mul_b;
    logic [2*N-1:0]  r_prod;
    logic [CW-1:0]   r_cnt;
    logic [N-1:0]    r_result, r_result_hi;
    logic            r_carry, r_zero, r_negative, r_overflow, r_out_valid;

    logic            w_in_ready, w_accept, w_mul_done;
    logic [N-1:0]    w_op_a, w_res;
    logic [N:0]      w_sum;
    logic            w_carry, w_ovf;
    logic [2*N-1:0]  w_addend, w_prod_nxt;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_op_a     = use_acc ? r_acc : a;
    assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(N - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && op == OP_MUL) w_state_nxt = S_MUL;
            S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_res   = '0;
        w_sum   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum   = {1'b0, w_op_a} + {1'b0, b};
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (w_op_a[N-1] == b[N-1]) && (w_res[N-1] != w_op_a[N-1]);
            end
            OP_SUB: begin
                w_sum   = {1'b0, w_op_a} - {1'b0, b};
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (w_op_a[N-1] != b[N-1]) && (w_res[N-1] != w_op_a[N-1]);
            end
            OP_AND: w_res = w_op_a & b;
            OP_OR:  w_res = w_op_a | b;
            OP_XOR: w_res = w_op_a ^ b;
            OP_NOT: w_res = ~w_op_a;
            OP_INC: begin
                w_sum   = {1'b0, w_op_a} + {1'b0, ONE};
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = !w_op_a[N-1] && w_res[N-1];
            end
            OP_DEC: begin
                w_sum   = {1'b0, w_op_a} - {1'b0, ONE};
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = w_op_a[N-1] && !w_res[N-1];
            end
            OP_SHL: begin
                w_res   = {w_op_a[N-2:0], 1'b0};
                w_carry = w_op_a[N-1];
            end
            OP_SHR: begin
                w_res   = {1'b0, w_op_a[N-1:1]};
                w_carry = w_op_a[0];
            end
            default: w_res = '0;
        endcase
    end

    // One partial product per cycle: bit r_cnt of B selects A shifted into place.
    assign w_addend   = r_mul_b[r_cnt] ? ({{N{1'b0}}, r_mul_a} << r_cnt) : '0;
    assign w_prod_nxt = r_prod + w_addend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_prod      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_negative  <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_mul_a <= w_op_a;
                r_mul_b <= b;
            end
            if (w_accept && op == OP_MUL) begin
                r_cnt  <= '0;
                r_prod <= '0;
            end else if (r_state == S_MUL) begin
                r_cnt  <= r_cnt + 1'b1;
                r_prod <= w_prod_nxt;
            end

            if (w_mul_done) begin
                r_result    <= w_prod_nxt[N-1:0];
                r_result_hi <= w_prod_nxt[2*N-1:N];
                r_carry     <= |w_prod_nxt[2*N-1:N];
                r_zero      <= (w_prod_nxt[N-1:0] == '0);
                r_negative  <= w_prod_nxt[N-1];
                r_overflow  <= 1'b0;
                r_out_valid <= 1'b1;
                r_acc       <= w_prod_nxt[N-1:0];
            end else if (w_accept && op != OP_MUL) begin
                r_result    <= w_res;
                r_result_hi <= '0;
                r_carry     <= w_carry;
                r_zero      <= (w_res == '0);
                r_negative  <= w_res[N-1];
                r_overflow  <= w_ovf;
                r_out_valid <= 1'b1;
                r_acc       <= w_res;
            end else if (w_accept || (r_out_valid && out_ready)) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign overflow  = r_overflow;
endmodule

// File: doc/nbit_seq_alu.md
# nbit_seq_alu

Registered, handshaked n-bit ALU: the sequential successor to the team's combinational n-bit ALU. It keeps the eight base operations and adds signed/zero flags, logical shifts, a multi-cycle shift-add multiplier and an internal accumulator that can replace operand A. It sits between an operand-issuing controller and a result consumer, with valid/ready flow control on both sides.

## Interface
- N, 8, operand/result width (N >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- in_valid  input  1  operation request
- in_ready  output  1  request accepted when in_valid & in_ready at a rising edge
- op  input  4  operation code
- use_acc  input  1  1: operand A taken from internal accumulator instead of port a
- a  input  N  operand A
- b  input  N  operand B
- out_valid  output  1  result registers hold a completed result
- out_ready  input  1  consumer accepts result when out_valid & out_ready
- result  output  N  result (low half for MUL)
- result_hi  output  N  high half for MUL, 0 for all other ops
- carry  output  1  carry/borrow/shift-out/MUL-overflow
- zero  output  1  result == 0 (low half only, MUL included)
- negative  output  1  result[N-1]
- overflow  output  1  signed overflow (ADD/SUB/INC/DEC only, else 0)

## Operation
- Operand A at accept = use_acc ? acc : a; captured with b and op in input registers.
- op codes: 0 ADD A+B, carry = bit N; 1 SUB A-B, carry = 1 when A<B unsigned (borrow); 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 INC A+1, carry = bit N; 7 DEC A-1, carry = 1 when A==0; 8 SHL A<<1, carry = A[N-1]; 9 SHR A>>1 logical, carry = A[0]; 10 MUL unsigned A*B, {result_hi,result} = 2N-bit product, carry = |result_hi; 11-15 reserved: result 0, all flags 0 except zero=1.
- Logic ops (2-5): carry = 0, overflow = 0.
- overflow: ADD/INC = same-sign operands, differing result sign; SUB/DEC = differing operand signs, result sign differs from A.
- FSM states: IDLE, MUL, HOLD.
- IDLE: in_ready = !out_valid | out_ready. Accepted non-MUL op -> result/flags registered same edge, out_valid=1, stay IDLE (pipelined). Accepted MUL -> MUL, counter = 0, product register cleared, out_valid drops at that edge if the old result was consumed.
- MUL: in_ready = 0; one shift-add step per cycle, N steps; after step N-1 -> HOLD? no: load result/flags, out_valid=1, return to IDLE.
- HOLD unused for non-stalled flow; entered only when MUL completes while previous result still unconsumed is impossible (in_ready gating guarantees consumption) — implement as IDLE+out_valid; no separate HOLD state required beyond IDLE/MUL. States are therefore IDLE and MUL.
- Accumulator acc (N bits): loaded with result (low half) on every completion edge; unaffected by reserved ops? No: reserved ops also load 0.
- Outputs hold stable while out_valid & !out_ready.
- Result regardless of out_ready timing: never overwritten before handshake.

## Timing
- Reset (rst_n=0 at edge): state IDLE, out_valid 0, in_ready 1 after reset, result/result_hi/acc 0, carry 0, zero 0, negative 0, overflow 0, MUL counter 0.
- Non-MUL latency: accept at edge k, out_valid=1 after edge k; throughput 1 op/cycle with out_ready held 1.
- MUL latency: accept at edge k, out_valid=1 after edge k+N; in_ready=0 for cycles k+1..k+N.
- Simultaneous consume and accept at one edge: new result replaces old, out_valid stays 1.
- use_acc back-to-back: op accepted at edge k+1 sees acc written at edge k.
- Reset mid-MUL: aborts, full reset values next cycle, no result emitted.
- Inputs sampled only at accepting edges; changes otherwise ignored.

## Test plan
- N=8: ADD a=0xF0,b=0x20 -> result 0x10, carry 1, overflow 0, zero 0, out_valid 1 cycle after accept.
- SUB a=0x05,b=0x07 -> result 0xFE, carry 1, negative 1; SUB a=0x80,b=0x01 -> 0x7F, overflow 1.
- MUL a=0xFF,b=0xFF -> result_hi 0xFE, result 0x01, carry 1; out_valid exactly 8 cycles after accept, in_ready 0 meanwhile.
- Accumulate: reset, then 4x ADD use_acc=1,b=0x40 -> results 0x40,0x80,0xC0,0x00 (carry 1, zero 1), one per cycle.
- Backpressure: out_ready=0 after result 0x33 -> result held, in_ready 0, next op not accepted; out_ready=1 -> new op accepted same edge.
- rst_n=0 at cycle 3 of MUL -> out_valid 0, acc 0, in_ready 1 next cycle; subsequent ADD 1+1 -> 0x02.
